// File: rtl/ones_count_sched.sv
// Round-robin scheduler sharing one shift-add ones-counter datapath among NUM_REQ requesters.
// Grant and datapath load are issued in the same IDLE cycle; done/result pulse for one cycle.
module ones_count_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_SIZE  = $clog2(DATA_SIZE + 1)
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [CNT_SIZE-1:0]           result,
  output logic                          busy,
  output logic                          err,
  output logic                          dp_load,
  output logic                          dp_shift,
  output logic [DATA_SIZE-1:0]          dp_data,
  input  logic                          dp_zero,
  input  logic [CNT_SIZE-1:0]           dp_cnt
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SC_W  = $clog2(DATA_SIZE + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state, state_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt;
  logic [PTR_W-1:0]     owner, owner_nxt;
  logic [PTR_W-1:0]     win;
  logic                 found;
  logic [SC_W-1:0]      shift_cnt, shift_cnt_nxt;
  logic                 err_q, err_nxt;

  logic [NUM_REQ-1:0]   gnt_c, done_c;
  logic                 load_c, shift_c;
  logic [DATA_SIZE-1:0] data_c;
  logic [CNT_SIZE-1:0]  result_c;

  logic [DATA_SIZE-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_SIZE +: DATA_SIZE];
  end

  // Rotating priority scan starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[PTR_W'((32'(ptr) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win   = PTR_W'((32'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      ptr       <= PTR_W'(NUM_REQ - 1);
      owner     <= '0;
      shift_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      shift_cnt <= shift_cnt_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    shift_cnt_nxt = shift_cnt;
    err_nxt       = err_q;
    gnt_c         = '0;
    done_c        = '0;
    load_c        = 1'b0;
    shift_c       = 1'b0;
    data_c        = '0;
    result_c      = '0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          gnt_c         = NUM_REQ'(1) << win;
          load_c        = 1'b1;
          data_c        = words[win];
          owner_nxt     = win;
          ptr_nxt       = win;
          shift_cnt_nxt = '0;
          state_nxt     = ST_RUN;
        end
      end
      ST_RUN: begin
        // A datapath that never empties is cut off after DATA_SIZE shifts.
        if (dp_zero) begin
          state_nxt = ST_DONE;
        end else if (shift_cnt == SC_W'(DATA_SIZE)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          shift_c       = 1'b1;
          shift_cnt_nxt = shift_cnt + SC_W'(1);
        end
      end
      ST_DONE: begin
        done_c    = NUM_REQ'(1) << owner;
        result_c  = dp_cnt;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign gnt      = rst_b ? gnt_c    : '0;
  assign done     = rst_b ? done_c   : '0;
  assign result   = rst_b ? result_c : '0;
  assign dp_load  = rst_b & load_c;
  assign dp_shift = rst_b & shift_c;
  assign dp_data  = rst_b ? data_c   : '0;
  assign busy     = rst_b & (state != ST_IDLE);
  assign err      = rst_b & err_q;

endmodule

// File: tb/tb_ones_count_sched.sv
// Bench for ones_count_sched: datapath stub, timeline reference model, vector table,
// directed multi-cycle sequences and a randomized requester phase.
module tb_ones_count_sched;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned CNT_SIZE  = $clog2(DATA_SIZE + 1);

  logic                         clk = 1'b0;
  logic                         rst_b;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt, done;
  logic [CNT_SIZE-1:0]          result;
  logic                         busy, err, dp_load, dp_shift, dp_zero;
  logic [DATA_SIZE-1:0]         dp_data;
  logic [CNT_SIZE-1:0]          dp_cnt;
  logic                         stuck;

  logic [DATA_SIZE-1:0]         sr;
  logic [CNT_SIZE-1:0]          cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  ones_count_sched #(.NUM_REQ(NUM_REQ), .DATA_SIZE(DATA_SIZE), .CNT_SIZE(CNT_SIZE)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .err(err),
    .dp_load(dp_load), .dp_shift(dp_shift), .dp_data(dp_data),
    .dp_zero(dp_zero), .dp_cnt(dp_cnt)
  );

  // Shift-add ones counter: shifts right, accumulating the bit that falls out.
  always @(posedge clk) begin
    if (!rst_b) begin
      sr  <= '0;
      cnt <= '0;
    end else if (dp_load) begin
      sr  <= dp_data;
      cnt <= '0;
    end else if (dp_shift) begin
      sr  <= sr >> 1;
      cnt <= cnt + CNT_SIZE'(sr[0]);
    end
  end
  assign dp_zero = !stuck && (sr == '0);
  assign dp_cnt  = cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int popcount(input logic [DATA_SIZE-1:0] w);
    int n = 0;
    for (int i = 0; i < DATA_SIZE; i++) if (w[i]) n++;
    return n;
  endfunction

  function automatic int top_bit_p(input logic [DATA_SIZE-1:0] w);
    int p = 0;
    for (int i = 0; i < DATA_SIZE; i++) if (w[i]) p = i + 1;
    return p;
  endfunction

  function automatic logic [DATA_SIZE-1:0] word_of(input int w);
    return req_data[w*DATA_SIZE +: DATA_SIZE];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int first_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: one job at a time, timeline derived from word length.
  bit                 m_active, m_err, m_stuckjob;
  int                 m_owner, m_gcyc, m_p, m_ones, m_ptr;
  logic [NUM_REQ-1:0] last_gnt;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0]   e_gnt, e_done;
    logic [DATA_SIZE-1:0] e_data;
    logic [CNT_SIZE-1:0]  e_res;
    logic                 e_shift, e_busy;
    int                   rel, w, idx;
    e_gnt = '0; e_done = '0; e_data = '0; e_res = '0; e_shift = 1'b0; e_busy = 1'b0;
    if (!rst_b) begin
      m_active = 1'b0;
      m_ptr    = NUM_REQ - 1;
      m_err    = 1'b0;
      last_gnt = '0;
    end else begin
      if (!m_active) begin
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (m_ptr + k) % NUM_REQ;
          if (w < 0 && req[idx]) w = idx;
        end
        if (w >= 0) begin
          e_gnt      = onehot(w);
          e_data     = word_of(w);
          m_active   = 1'b1;
          m_owner    = w;
          m_gcyc     = cyc;
          m_ptr      = w;
          m_stuckjob = stuck;
          m_p        = stuck ? DATA_SIZE : top_bit_p(word_of(w));
          m_ones     = popcount(word_of(w));
        end
      end else begin
        rel     = cyc - m_gcyc;
        e_busy  = 1'b1;
        e_shift = (rel >= 1) && (rel <= m_p);
        if (rel == m_p + 2) begin
          e_done   = onehot(m_owner);
          e_res    = CNT_SIZE'(m_ones);
          m_active = 1'b0;
          if (m_stuckjob) m_err = 1'b1;
        end
      end
      last_gnt = gnt;
    end
    check("mon_gnt",      64'(gnt),      64'(e_gnt));
    check("mon_dp_load",  64'(dp_load),  64'(|e_gnt));
    check("mon_dp_data",  64'(dp_data),  64'(e_data));
    check("mon_dp_shift", 64'(dp_shift), 64'(e_shift));
    check("mon_done",     64'(done),     64'(e_done));
    check("mon_result",   64'(result),   64'(e_res));
    check("mon_busy",     64'(busy),     64'(e_busy));
    check("mon_err",      64'(err),      64'(m_err));
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_b = 1'b0;
    @(posedge clk); #1 rst_b = 1'b1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("wait_idle", 64'(busy), 64'(0));
  endtask

  // One job from an idle scheduler: winner, result, done latency and shift count.
  task automatic run_vec(input logic [NUM_REQ-1:0] r, input logic [DATA_SIZE-1:0] d,
                         input int win, input int res, input int lat);
    int gc, shifts;
    @(posedge clk); #1;
    req      = r;
    req_data = {NUM_REQ{d}};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    check("vec_gnt", 64'(gnt), 64'(onehot(win)));
    gc = cyc;
    @(posedge clk); #1 req = '0;
    shifts = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dp_shift) shifts++;
      if (done != '0) break;
    end
    check("vec_done",    64'(done),   64'(onehot(win)));
    check("vec_result",  64'(result), 64'(res));
    check("vec_latency", 64'(cyc - gc), 64'(lat));
    check("vec_shifts",  64'(shifts), 64'(lat - 2));
  endtask

  function automatic logic [DATA_SIZE-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return DATA_SIZE'(1) << $urandom_range(0, DATA_SIZE - 1);
      2:       return '1;
      default: return DATA_SIZE'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [NUM_REQ-1:0]   r;
    logic [DATA_SIZE-1:0] d;
    int                   win;
    int                   res;
    int                   lat;
  } vec_t;

  initial begin
    vec_t               tbl [8];
    int                 gi [5];
    int                 gcy [5];
    int                 n, nd;
    logic               seen_done;
    logic [NUM_REQ-1:0] ng;

    tbl[0] = '{4'b0001, 8'hB5, 0, 5, 10};
    tbl[1] = '{4'b0010, 8'h00, 1, 0, 2};
    tbl[2] = '{4'b0100, 8'h80, 2, 1, 10};
    tbl[3] = '{4'b1000, 8'h07, 3, 3, 5};
    tbl[4] = '{4'b1010, 8'h0F, 1, 4, 6};
    tbl[5] = '{4'b1010, 8'h3C, 3, 4, 8};
    tbl[6] = '{4'b0101, 8'h01, 0, 1, 3};
    tbl[7] = '{4'b1111, 8'hFF, 1, 8, 10};

    rst_b = 1'b0; req = '0; req_data = '0; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_err",  64'(err),  64'(0));

    for (int i = 0; i < 8; i++) run_vec(tbl[i].r, tbl[i].d, tbl[i].win, tbl[i].res, tbl[i].lat);

    // All requesters held high: strict rotation with minimum spacing.
    do_reset();
    req_data = {NUM_REQ{DATA_SIZE'(1)}};
    req      = '1;
    n = 0;
    for (int k = 0; k < 60 && n < 5; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        gi[n]  = first_idx(gnt);
        gcy[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1 req = '0;
    check("rr_count", 64'(n), 64'(5));
    for (int i = 0; i < n; i++) begin
      check("rr_order", 64'(gi[i]), 64'(i % NUM_REQ));
      if (i > 0) check("rr_spacing", 64'(gcy[i] - gcy[i-1]), 64'(4));
    end
    wait_idle();

    // Reset in the middle of a job aborts it silently.
    do_reset();
    req_data = {NUM_REQ{8'hFF}};
    req      = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    check("abort_gnt", 64'(gnt), 64'(4'b0100));
    @(posedge clk); #1 req = '0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    @(posedge clk); #1 rst_b = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_err",  64'(err),  64'(0));
    nd = (done != '0) ? 1 : 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done != '0) nd++;
    end
    check("abort_no_done", 64'(nd), 64'(0));
    run_vec(4'b0001, 8'h03, 0, 2, 4);

    // Datapath never reports zero: timeout sets the sticky error.
    stuck = 1'b1;
    run_vec(4'b0100, 8'h01, 2, 1, 10);
    stuck = 1'b0;
    check("timeout_err", 64'(err), 64'(1));
    run_vec(4'b0001, 8'h03, 0, 2, 4);
    check("timeout_err_sticky", 64'(err), 64'(1));
    do_reset();
    @(negedge clk);
    check("timeout_err_cleared", 64'(err), 64'(0));

    // Owner drops and re-asserts mid-job; its done still pulses and the other index wins next.
    req_data = {8'h00, 8'h00, 8'h0F, 8'h05};
    req      = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    check("drop_gnt", 64'(gnt), 64'(4'b0010));
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1;
    @(posedge clk); #1 req = 4'b0011;
    seen_done = 1'b0;
    ng = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done[1]) seen_done = 1'b1;
      if (gnt != '0) begin
        ng = gnt;
        break;
      end
    end
    check("drop_done_seen", 64'(seen_done), 64'(1));
    check("drop_next_gnt",  64'(ng),        64'(4'b0001));
    @(posedge clk); #1 req = '0;
    wait_idle();

    // Randomized requesters following the hold-until-grant protocol.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_b = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && last_gnt[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*DATA_SIZE +: DATA_SIZE] = rand_word();
        end
      end
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    req   = '0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, %0d failed", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
